// File: rtl/avalon_mem_slave.sv
// Avalon-MM byte-addressed memory slave model: data and reset-vector windows, programmable
// wait states, byte-lane masking, selectable endianness, sticky error flag and a read-only backdoor.
module avalon_mem_slave #(
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter logic [31:0] DATA_BASE   = 32'h0000_0000,
    parameter logic [31:0] INSTR_BASE  = 32'hBFC0_0000,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_rdata
);
    typedef enum logic {IDLE, STALL} state_e;

    localparam int unsigned    AW         = $clog2(DEPTH_BYTES);
    localparam int unsigned    CNT_W      = $clog2(WAIT_CYCLES + 2);
    localparam logic [CNT_W-1:0] WAIT_C   = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]  ALIGN_MASK = ~AW'(3);

    // Both windows share one array; the top index bit selects the instruction window.
    logic [7:0] mem_q [2*DEPTH_BYTES];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             err_q, err_d;
    logic [69:0]      req_vec, snap_q;
    logic             req, accept, restart, mem_we, acc_hit;
    logic [AW+1:0]    acc_dec, dbg_dec;
    logic [AW:0]      acc_idx;

    // Returns {hit, window, word-aligned byte offset}.
    function automatic logic [AW+1:0] decode(input logic [31:0] a);
        logic [31:0] d_off;
        logic [31:0] i_off;
        d_off  = a - DATA_BASE;
        i_off  = a - INSTR_BASE;
        decode = '0;
        if (d_off < DEPTH_BYTES)
            decode = {1'b1, 1'b0, d_off[AW-1:0] & ALIGN_MASK};
        else if (i_off < DEPTH_BYTES)
            decode = {1'b1, 1'b1, i_off[AW-1:0] & ALIGN_MASK};
    endfunction

    function automatic logic [AW:0] lane_off(input int lane);
        return BIG_ENDIAN ? (AW+1)'(3 - lane) : (AW+1)'(lane);
    endfunction

    function automatic logic [31:0] rd_word(input logic [AW:0] base);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = mem_q[base | lane_off(i)];
        return w;
    endfunction

    assign req         = read | write;
    assign req_vec     = {address, read, write, byteenable, writedata};
    assign waitrequest = req && ((state_q == IDLE) ? (WAIT_CYCLES > 0) : (cnt_q != WAIT_C));
    assign accept      = req && !waitrequest;
    // A request that moves while stalled is a master protocol violation.
    assign restart     = (state_q == STALL) && (cnt_q != WAIT_C) && (req_vec != snap_q);
    assign acc_dec     = decode(address);
    assign acc_hit     = acc_dec[AW+1];
    assign acc_idx     = acc_dec[AW:0];
    assign dbg_dec     = decode(dbg_addr);
    assign dbg_rdata   = dbg_dec[AW+1] ? rd_word(dbg_dec[AW:0]) : 32'hDEAD_BEEF;
    assign readdata    = readdata_q;
    assign err         = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        readdata_d = readdata_q;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && (WAIT_CYCLES > 0)) begin
                    state_d = STALL;
                    cnt_d   = CNT_ONE;
                end
            end
            STALL: begin
                if (restart) begin
                    err_d = 1'b1;
                    if (req) begin
                        cnt_d = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != WAIT_C) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (accept) begin
            if (read && write) begin
                err_d = 1'b1;
            end else begin
                if ((address[1:0] != 2'b00) || !acc_hit)
                    err_d = 1'b1;
                if (read)
                    readdata_d = acc_hit ? rd_word(acc_idx) : 32'h0;
                mem_we = write && acc_hit;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            readdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            err_q      <= err_d;
        end
    end

    // Request snapshot and storage are not reset; memory survives reset by design.
    always_ff @(posedge clk) begin
        snap_q <= req_vec;
        if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (byteenable[i])
                    mem_q[acc_idx | lane_off(i)] <= writedata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_avalon_mem_slave.sv
// Bench for avalon_mem_slave: three instances (2 waits big-endian, 2 waits little-endian, 0 waits).
module tb_avalon_mem_slave;
    localparam logic [31:0] IB = 32'hBFC0_0000;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0][31:0] address, writedata, readdata, dbg_addr, dbg_rdata;
    logic [2:0]       read, write, waitrequest, err;
    logic [2:0][3:0]  byteenable;
    int               errors = 0;
    int               checks = 0;
    logic [31:0]      exp_q[$];
    logic [31:0]      lane_word;

    always #5 clk = ~clk;

    avalon_mem_slave #(.WAIT_CYCLES(2), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .reset(reset), .address(address[0]), .read(read[0]), .write(write[0]),
        .byteenable(byteenable[0]), .writedata(writedata[0]), .waitrequest(waitrequest[0]),
        .readdata(readdata[0]), .err(err[0]), .dbg_addr(dbg_addr[0]), .dbg_rdata(dbg_rdata[0]));

    avalon_mem_slave #(.WAIT_CYCLES(2), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset(reset), .address(address[1]), .read(read[1]), .write(write[1]),
        .byteenable(byteenable[1]), .writedata(writedata[1]), .waitrequest(waitrequest[1]),
        .readdata(readdata[1]), .err(err[1]), .dbg_addr(dbg_addr[1]), .dbg_rdata(dbg_rdata[1]));

    avalon_mem_slave #(.WAIT_CYCLES(0), .BIG_ENDIAN(1'b1)) dut_w0 (
        .clk(clk), .reset(reset), .address(address[2]), .read(read[2]), .write(write[2]),
        .byteenable(byteenable[2]), .writedata(writedata[2]), .waitrequest(waitrequest[2]),
        .readdata(readdata[2]), .err(err[2]), .dbg_addr(dbg_addr[2]), .dbg_rdata(dbg_rdata[2]));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    // Called just after a rising edge; returns just after the accept edge.
    task automatic bus_xfer(input int u, input logic [31:0] a, input logic rd, input logic wr,
                            input logic [3:0] be, input logic [31:0] wd, output int waits);
        address[u] = a; read[u] = rd; write[u] = wr; byteenable[u] = be; writedata[u] = wd;
        waits = 0;
        @(negedge clk);
        while (waitrequest[u] && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 20) begin
            checks++; errors++;
            $display("FAIL xfer_timeout: unit %0d addr %h stalled %0d cycles", u, a, waits);
        end
        @(posedge clk); #1;
        read[u] = 1'b0; write[u] = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin
            address[u] = '0; read[u] = 1'b0; write[u] = 1'b0;
            byteenable[u] = '0; writedata[u] = '0; dbg_addr[u] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            checks++; if (waitrequest[u] !== 1'b0) begin errors++; $display("FAIL rst_wait u%0d: got %b want 0", u, waitrequest[u]); end
            checks++; if (readdata[u] !== 32'h0) begin errors++; $display("FAIL rst_rdata u%0d: got %h want 0", u, readdata[u]); end
            checks++; if (err[u] !== 1'b0) begin errors++; $display("FAIL rst_err u%0d: got %b want 0", u, err[u]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_wait_read();
        int w;
        logic [31:0] exp;
        bus_xfer(0, IB, 1'b0, 1'b1, 4'hF, 32'h8C01_0064, w);
        checks++; if (w !== 2) begin errors++; $display("FAIL wr_waits: got %0d want 2", w); end
        exp_q.push_back(32'h8C01_0064);
        bus_xfer(0, IB, 1'b1, 1'b0, 4'h0, 32'h0, w);
        checks++; if (w !== 2) begin errors++; $display("FAIL rd_waits: got %0d want 2", w); end
        exp = exp_q.pop_front();
        checks++; if (readdata[0] !== exp) begin errors++; $display("FAIL rd_instr: got %h want %h", readdata[0], exp); end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", err[0]); end
    endtask

    task automatic test_endian();
        int w;
        logic [31:0] exp;
        bus_xfer(0, 32'hC8, 1'b0, 1'b1, 4'hF, 32'hAABB_CCDD, w);
        bus_xfer(1, 32'hC8, 1'b0, 1'b1, 4'hF, 32'hAABB_CCDD, w);
        dbg_addr[0] = 32'hC8; dbg_addr[1] = 32'hC8;
        #1;
        checks++; if (dbg_rdata[0] !== 32'hAABB_CCDD) begin errors++; $display("FAIL dbg_be: got %h want AABBCCDD", dbg_rdata[0]); end
        checks++; if (dbg_rdata[1] !== 32'hAABB_CCDD) begin errors++; $display("FAIL dbg_le: got %h want AABBCCDD", dbg_rdata[1]); end
        checks++; if (dut_be.mem_q[200] !== 8'hAA) begin errors++; $display("FAIL be_byte200: got %h want AA", dut_be.mem_q[200]); end
        checks++; if (dut_be.mem_q[203] !== 8'hDD) begin errors++; $display("FAIL be_byte203: got %h want DD", dut_be.mem_q[203]); end
        checks++; if (dut_le.mem_q[200] !== 8'hDD) begin errors++; $display("FAIL le_byte200: got %h want DD", dut_le.mem_q[200]); end
        checks++; if (dut_le.mem_q[203] !== 8'hAA) begin errors++; $display("FAIL le_byte203: got %h want AA", dut_le.mem_q[203]); end
        exp_q.push_back(32'hAABB_CCDD);
        bus_xfer(1, 32'hC8, 1'b1, 1'b0, 4'h0, 32'h0, w);
        exp = exp_q.pop_front();
        checks++; if (readdata[1] !== exp) begin errors++; $display("FAIL le_read: got %h want %h", readdata[1], exp); end
    endtask

    task automatic test_byte_lanes();
        int w;
        logic [31:0] exp;
        bus_xfer(0, 32'h100, 1'b0, 1'b1, 4'hF, 32'h1122_3344, w);
        bus_xfer(0, 32'h100, 1'b0, 1'b1, 4'b0010, 32'h0000_EE00, w);
        lane_word = merge(32'h1122_3344, 32'h0000_EE00, 4'b0010);
        exp_q.push_back(lane_word);
        bus_xfer(0, 32'h100, 1'b1, 1'b0, 4'h0, 32'h0, w);
        exp = exp_q.pop_front();
        checks++; if (readdata[0] !== exp) begin errors++; $display("FAIL lane_read: got %h want %h", readdata[0], exp); end
        bus_xfer(0, 32'h100, 1'b0, 1'b1, 4'b0000, 32'hFFFF_FFFF, w);
        dbg_addr[0] = 32'h100;
        #1;
        checks++; if (dbg_rdata[0] !== lane_word) begin errors++; $display("FAIL be_none: got %h want %h", dbg_rdata[0], lane_word); end
    endtask

    task automatic test_errors();
        int w;
        logic [31:0] exp;
        bus_xfer(0, 32'h104, 1'b0, 1'b1, 4'hF, 32'hCAFE_F00D, w);
        // Move the address while stalled: count restarts and err latches.
        address[0] = 32'h100; read[0] = 1'b1; byteenable[0] = 4'h0;
        exp_q.push_back(32'hCAFE_F00D);
        @(negedge clk);
        @(negedge clk);
        address[0] = 32'h104;
        w = 0;
        while (waitrequest[0] && w < 20) begin w++; @(negedge clk); end
        @(posedge clk); #1;
        read[0] = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (readdata[0] !== exp) begin errors++; $display("FAIL chg_read: got %h want %h", readdata[0], exp); end
        checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL chg_err: got %b want 1", err[0]); end

        pulse_reset();
        exp_q.push_back(32'h0);
        bus_xfer(0, 32'h8000_0000, 1'b1, 1'b0, 4'h0, 32'h0, w);
        exp = exp_q.pop_front();
        checks++; if (w !== 2) begin errors++; $display("FAIL miss_waits: got %0d want 2", w); end
        checks++; if (readdata[0] !== exp) begin errors++; $display("FAIL miss_rdata: got %h want %h", readdata[0], exp); end
        checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL miss_err: got %b want 1", err[0]); end
        exp_q.push_back(32'h8C01_0064);
        bus_xfer(0, IB, 1'b1, 1'b0, 4'h0, 32'h0, w);
        exp = exp_q.pop_front();
        checks++; if (readdata[0] !== exp) begin errors++; $display("FAIL post_miss_read: got %h want %h", readdata[0], exp); end
        checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err[0]); end

        pulse_reset();
        bus_xfer(0, 32'h0, 1'b0, 1'b1, 4'hF, 32'h1234_5678, w);
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL good_wr_err: got %b want 0", err[0]); end
        exp_q.push_back(32'h0);
        bus_xfer(0, 32'h0, 1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, w);
        exp = exp_q.pop_front();
        checks++; if (w !== 2) begin errors++; $display("FAIL rw_waits: got %0d want 2", w); end
        checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL rw_err: got %b want 1", err[0]); end
        checks++; if (readdata[0] !== exp) begin errors++; $display("FAIL rw_rdata: got %h want %h", readdata[0], exp); end
        dbg_addr[0] = 32'h0;
        #1;
        checks++; if (dbg_rdata[0] !== 32'h1234_5678) begin errors++; $display("FAIL rw_mem: got %h want 12345678", dbg_rdata[0]); end

        pulse_reset();
        exp_q.push_back(32'hCAFE_F00D);
        bus_xfer(0, 32'h106, 1'b1, 1'b0, 4'h0, 32'h0, w);
        exp = exp_q.pop_front();
        checks++; if (readdata[0] !== exp) begin errors++; $display("FAIL misalign_rdata: got %h want %h", readdata[0], exp); end
        checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b want 1", err[0]); end

        bus_xfer(0, 32'hFFC, 1'b0, 1'b1, 4'hF, 32'h0BAD_C0DE, w);
        dbg_addr[0] = 32'hFFC;
        #1;
        checks++; if (dbg_rdata[0] !== 32'h0BAD_C0DE) begin errors++; $display("FAIL dbg_top: got %h want 0BADC0DE", dbg_rdata[0]); end
        dbg_addr[0] = 32'h1000;
        #1;
        checks++; if (dbg_rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dbg_past_data: got %h want DEADBEEF", dbg_rdata[0]); end
        dbg_addr[0] = IB + 32'h1000;
        #1;
        checks++; if (dbg_rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dbg_past_instr: got %h want DEADBEEF", dbg_rdata[0]); end
    endtask

    task automatic test_reset_mid_stall();
        int w;
        pulse_reset();
        bus_xfer(0, 32'h40, 1'b0, 1'b1, 4'hF, 32'h5A5A_5A5A, w);
        address[0] = 32'h40; write[0] = 1'b1; byteenable[0] = 4'hF; writedata[0] = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        checks++; if (waitrequest[0] !== 1'b1) begin errors++; $display("FAIL stall_wait: got %b want 1", waitrequest[0]); end
        #1;
        reset = 1'b1; write[0] = 1'b0;
        #1;
        checks++; if (waitrequest[0] !== 1'b0) begin errors++; $display("FAIL rst_stall_wait: got %b want 0", waitrequest[0]); end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL rst_stall_err: got %b want 0", err[0]); end
        @(posedge clk); #1;
        reset = 1'b0;
        dbg_addr[0] = 32'h40;
        #1;
        checks++; if (dbg_rdata[0] !== 32'h5A5A_5A5A) begin errors++; $display("FAIL rst_stall_mem: got %h want 5A5A5A5A", dbg_rdata[0]); end
        @(posedge clk); #1;
        bus_xfer(0, 32'h44, 1'b0, 1'b1, 4'hF, 32'h0000_0044, w);
        checks++; if (w !== 2) begin errors++; $display("FAIL post_rst_waits: got %0d want 2", w); end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [31:0] exp;
        exp_q.push_back(32'h8C01_0064);
        exp_q.push_back(lane_word);
        bus_xfer(0, IB, 1'b1, 1'b0, 4'h0, 32'h0, w);
        exp = exp_q.pop_front();
        checks++; if (readdata[0] !== exp) begin errors++; $display("FAIL b2b_rd0: got %h want %h", readdata[0], exp); end
        bus_xfer(0, 32'h100, 1'b1, 1'b0, 4'h0, 32'h0, w);
        exp = exp_q.pop_front();
        checks++; if (w !== 2) begin errors++; $display("FAIL b2b_waits: got %0d want 2", w); end
        checks++; if (readdata[0] !== exp) begin errors++; $display("FAIL b2b_rd1: got %h want %h", readdata[0], exp); end

        for (int i = 0; i < 10; i++) begin
            bus_xfer(2, 32'h200 + 32'(4*i), 1'b0, 1'b1, 4'hF, 32'(i+1) * 32'h0101_0101, w);
            checks++; if (w !== 0) begin errors++; $display("FAIL w0_wr_waits %0d: got %0d want 0", i, w); end
        end
        read[2] = 1'b1;
        byteenable[2] = 4'h0;
        for (int i = 0; i < 10; i++) begin
            address[2] = 32'h200 + 32'(4*i);
            exp_q.push_back(32'(i+1) * 32'h0101_0101);
            @(negedge clk);
            checks++; if (waitrequest[2] !== 1'b0) begin errors++; $display("FAIL w0_wait %0d: got %b want 0", i, waitrequest[2]); end
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            checks++; if (readdata[2] !== exp) begin errors++; $display("FAIL w0_read %0d: got %h want %h", i, readdata[2], exp); end
        end
        read[2] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wait_read();
        test_endian();
        test_byte_lanes();
        test_errors();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
